mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/mem_wb_reg.sv | 58 +++++
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM state
// encoding, control-bit positions inside the EX/MEM control fields,
// and the data/register widths.
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int WB_W   = 2;
    localparam int MEM_W  = 3;
    localparam int CNT_W  = 8;

    // i_MEM_control bit positions
    localparam int MEM_BRANCH = 2;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 0;

    // i_WB_control bit positions
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Loads either the incoming fields or a bubble
// (all zeros, which also clears WB control so nothing is written back).
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_bubble,
    input  logic [DATA_W-1:0] i_read_data,
    input  logic [DATA_W-1:0] i_result,
    input  logic [REG_W-1:0]  i_write_reg,
    input  logic [WB_W-1:0]   i_wb_control,
    output logic [DATA_W-1:0] o_read_data,
    output logic [DATA_W-1:0] o_result,
    output logic [REG_W-1:0]  o_write_reg,
    output logic [WB_W-1:0]   o_wb_control
);

    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [REG_W-1:0]  write_reg_q, write_reg_d;
    logic [WB_W-1:0]   wb_control_q, wb_control_d;

    // Select between the incoming instruction and a bubble.
    always_comb begin
        read_data_d  = i_read_data;
        result_d     = i_result;
        write_reg_d  = i_write_reg;
        wb_control_d = i_wb_control;
        if (i_load_bubble) begin
            read_data_d  = '0;
            result_d     = '0;
            write_reg_d  = '0;
            wb_control_d = '0;
        end
    end

    // Pipeline register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            read_data_q  <= '0;
            result_q     <= '0;
            write_reg_q  <= '0;
            wb_control_q <= '0;
        end else begin
            read_data_q  <= read_data_d;
            result_q     <= result_d;
            write_reg_q  <= write_reg_d;
            wb_control_q <= wb_control_d;
        end
    end

    assign o_read_data  = read_data_q;
    assign o_result     = result_q;
    assign o_write_reg  = write_reg_q;
    assign o_wb_control = wb_control_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: data-memory handshake with stall/timeout handling,
// branch redirect, and MEM/WB capture.
// Optional build macro DMEM_ALIGN_CHECK_EN: when defined, misaligned
// word accesses are rejected with an o_misalign pulse; when undefined the
// low two address bits are forced to zero and o_misalign is tied low.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no request outstanding; decode EX/MEM, start access if any
// ST_ACCESS | request held on the dmem port until ready or timeout
module mem_access_unit
    import mem_stage_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_branch_pc,
    input  logic [DATA_W-1:0] i_result,
    input  logic [DATA_W-1:0] i_read_data2,
    input  logic              i_zero,
    input  logic [REG_W-1:0]  i_write_reg,
    input  logic [WB_W-1:0]   i_WB_control,
    input  logic [MEM_W-1:0]  i_MEM_control,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [DATA_W-1:0] o_dmem_addr,
    output logic [DATA_W-1:0] o_dmem_wdata,
    input  logic [DATA_W-1:0] i_dmem_rdata,
    input  logic              i_dmem_ready,
    output logic              o_pc_src,
    output logic [DATA_W-1:0] o_branch_pc,
    output logic              o_stall,
    output logic [DATA_W-1:0] o_read_data,
    output logic [DATA_W-1:0] o_result,
    output logic [REG_W-1:0]  o_write_reg,
    output logic [WB_W-1:0]   o_WB_control,
    output logic              o_dmem_err,
    output logic              o_misalign
);

    // Last ACCESS cycle index before the wait is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DMEM_TIMEOUT - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              mem_read, mem_write, branch;
    logic              is_access, is_illegal, misalign;
    logic              stall, load_bubble;
    logic [DATA_W-1:0] wb_read_data;
    logic [DATA_W-1:0] dmem_addr;

    assign mem_read   = i_MEM_control[MEM_READ];
    assign mem_write  = i_MEM_control[MEM_WRITE];
    assign branch     = i_MEM_control[MEM_BRANCH];
    assign is_access  = mem_read ^ mem_write;
    assign is_illegal = mem_read & mem_write;

`ifdef DMEM_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign misalign  = is_access && (i_result[1:0] != 2'b00);
    assign dmem_addr = i_result;

    // A rejected misaligned access is flagged for one cycle.
    always_comb begin
        misalign_d = (state_q == ST_IDLE) && misalign;
    end

    // Misalign pulse register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign o_misalign = misalign_q;
`else
    assign misalign   = 1'b0;
    assign dmem_addr  = {i_result[DATA_W-1:2], 2'b00};
    assign o_misalign = 1'b0;
`endif

    // Next-state, wait counter, stall and MEM/WB load selection.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = 1'b0;
        stall        = 1'b0;
        load_bubble  = 1'b0;
        wb_read_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (is_illegal) begin
                    err_d       = 1'b1;
                    load_bubble = 1'b1;
                end else if (misalign) begin
                    load_bubble = 1'b1;
                end else if (is_access) begin
                    stall       = 1'b1;
                    load_bubble = 1'b1;
                    state_d     = ST_ACCESS;
                    cnt_d       = '0;
                end
            end
            ST_ACCESS: begin
                if (i_dmem_ready) begin
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                    wb_read_data = mem_read ? i_dmem_rdata : '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Give up: release the pipeline with a bubble.
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    err_d       = 1'b1;
                    load_bubble = 1'b1;
                end else begin
                    stall       = 1'b1;
                    load_bubble = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and error-pulse registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Combinational outputs are held at zero while reset is asserted.
    assign o_stall      = i_rst_n & stall;
    assign o_dmem_req   = i_rst_n & (state_q == ST_ACCESS);
    assign o_dmem_we    = o_dmem_req & mem_write;
    assign o_dmem_addr  = i_rst_n ? dmem_addr : '0;
    assign o_dmem_wdata = i_rst_n ? i_read_data2 : '0;
    assign o_pc_src     = i_rst_n & branch & i_zero;
    assign o_branch_pc  = i_rst_n ? i_branch_pc : '0;
    assign o_dmem_err   = err_q;

    mem_wb_reg u_mem_wb_reg (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_load_bubble (load_bubble),
        .i_read_data   (wb_read_data),
        .i_result      (i_result),
        .i_write_reg   (i_write_reg),
        .i_wb_control  (i_WB_control),
        .o_read_data   (o_read_data),
        .o_result      (o_result),
        .o_write_reg   (o_write_reg),
        .o_wb_control  (o_WB_control)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver issues instructions and
// pushes expected outcomes; the monitor pops one per retired instruction.
module tb_mem_access_unit;

    localparam int TO = 16;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_branch_pc = '0, i_result = '0, i_read_data2 = '0;
    logic        i_zero = 1'b0;
    logic [4:0]  i_write_reg = '0;
    logic [1:0]  i_WB_control = '0;
    logic [2:0]  i_MEM_control = '0;
    logic        o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [31:0] i_dmem_rdata = '0;
    logic        i_dmem_ready = 1'b0;
    logic        o_pc_src;
    logic [31:0] o_branch_pc;
    logic        o_stall;
    logic [31:0] o_read_data, o_result;
    logic [4:0]  o_write_reg;
    logic [1:0]  o_WB_control;
    logic        o_dmem_err, o_misalign;

    mem_access_unit #(.DMEM_TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_branch_pc(i_branch_pc), .i_result(i_result), .i_read_data2(i_read_data2),
        .i_zero(i_zero), .i_write_reg(i_write_reg), .i_WB_control(i_WB_control),
        .i_MEM_control(i_MEM_control),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .i_dmem_rdata(i_dmem_rdata), .i_dmem_ready(i_dmem_ready),
        .o_pc_src(o_pc_src), .o_branch_pc(o_branch_pc), .o_stall(o_stall),
        .o_read_data(o_read_data), .o_result(o_result), .o_write_reg(o_write_reg),
        .o_WB_control(o_WB_control), .o_dmem_err(o_dmem_err), .o_misalign(o_misalign)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          stalls;
        int          reqs;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pc_src;
        logic [31:0] bpc;
        logic [31:0] rd;
        logic [31:0] res;
        logic [4:0]  wr;
        logic [1:0]  wb;
        logic        err;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference outcome of one instruction. lat = ACCESS cycle on which the
    // memory answers (1..TO), or 0 if it never answers.
    function automatic exp_t model(input logic [2:0] mc, input logic [1:0] wb,
                                   input logic [31:0] res, input logic [31:0] wd2,
                                   input logic [31:0] bpc, input logic zero,
                                   input logic [4:0] wr, input int lat,
                                   input logic [31:0] rdata);
        exp_t e;
        bit rd, wrt, acc, ill, mis, bubble;
        rd  = mc[1];
        wrt = mc[0];
        acc = rd ^ wrt;
        ill = rd & wrt;
        mis = ALIGN_EN && acc && (res % 4 != 0);
        e.stalls = 0; e.reqs = 0; e.err = 1'b0; e.mis = mis;
        e.we     = wrt;
        e.addr   = ALIGN_EN ? res : (res / 4) * 4;
        e.wdata  = wd2;
        e.pc_src = mc[2] & zero;
        e.bpc    = bpc;
        bubble   = 1'b0;
        e.rd     = 32'h0;
        if (ill) begin
            e.err  = 1'b1;
            bubble = 1'b1;
        end else if (mis) begin
            bubble = 1'b1;
        end else if (acc) begin
            if (lat == 0) begin
                e.reqs   = TO;
                e.stalls = TO;
                e.err    = 1'b1;
                bubble   = 1'b1;
            end else begin
                e.reqs   = lat;
                e.stalls = lat;
                e.rd     = rd ? rdata : 32'h0;
            end
        end
        e.res = bubble ? 32'h0 : res;
        e.wr  = bubble ? 5'h0  : wr;
        e.wb  = bubble ? 2'h0  : wb;
        return e;
    endfunction

    task automatic run_instr(input logic [2:0] mc, input logic [1:0] wb,
                             input logic [31:0] res, input logic [31:0] wd2,
                             input logic [31:0] bpc, input logic zero,
                             input logic [4:0] wr, input int lat,
                             input logic [31:0] rdata);
        int acc_cyc;
        bit done;
        @(posedge i_clk);
        #1;
        i_MEM_control = mc; i_WB_control = wb; i_result = res; i_read_data2 = wd2;
        i_branch_pc = bpc; i_zero = zero; i_write_reg = wr;
        i_dmem_ready = 1'b0; i_dmem_rdata = $urandom;
        q.push_back(model(mc, wb, res, wd2, bpc, zero, wr, lat, rdata));
        acc_cyc = 0;
        done = 1'b0;
        for (int c = 0; c < 3 * TO; c++) begin
            @(negedge i_clk);
            if (o_dmem_req) begin
                acc_cyc++;
                if (lat != 0 && acc_cyc == lat) begin
                    i_dmem_ready = 1'b1;
                    i_dmem_rdata = rdata;
                end
            end
            #1;
            if (!o_stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL retire_timeout: stall still high after %0d cycles, expected release", 3 * TO);
        end
    endtask

    // Monitor: checks dmem request fields, stall length and MEM/WB contents.
    initial begin
        exp_t cur;
        int   stall_cnt;
        int   req_cnt;
        bit   pend;
        bit   prev_stall;
        stall_cnt = 0; req_cnt = 0; pend = 1'b0; prev_stall = 1'b0;
        forever begin
            @(negedge i_clk);
            #2;
            if (mon_en) begin
                if (pend) begin
                    chk("wb_ctl",    32'(o_WB_control), 32'(cur.wb));
                    chk("read_data", o_read_data,       cur.rd);
                    chk("result",    o_result,          cur.res);
                    chk("write_reg", 32'(o_write_reg),  32'(cur.wr));
                    chk("dmem_err",  32'(o_dmem_err),   32'(cur.err));
                    chk("misalign",  32'(o_misalign),   32'(cur.mis));
                    pend = 1'b0;
                end else if (prev_stall) begin
                    chk("bubble_wb",  32'(o_WB_control), 32'h0);
                    chk("bubble_rd",  o_read_data,       32'h0);
                    chk("bubble_res", o_result,          32'h0);
                    chk("bubble_err", 32'(o_dmem_err),   32'h0);
                end
                if (q.size() != 0) begin
                    if (o_dmem_req) begin
                        req_cnt++;
                        chk("dmem_we",    32'(o_dmem_we), 32'(q[0].we));
                        chk("dmem_addr",  o_dmem_addr,    q[0].addr);
                        chk("dmem_wdata", o_dmem_wdata,   q[0].wdata);
                    end
                    if (!o_stall) begin
                        cur = q.pop_front();
                        chk("stall_cycles", 32'(stall_cnt), 32'(cur.stalls));
                        chk("req_cycles",   32'(req_cnt),   32'(cur.reqs));
                        chk("pc_src",       32'(o_pc_src),  32'(cur.pc_src));
                        chk("branch_pc",    o_branch_pc,    cur.bpc);
                        pend = 1'b1;
                        stall_cnt = 0;
                        req_cnt = 0;
                    end else begin
                        stall_cnt++;
                    end
                end
                prev_stall = o_stall;
            end
        end
    end

    initial begin
        logic [2:0]  mc;
        logic [31:0] res;
        int          sel;
        int          lat;

        // Reset with busy-looking inputs: everything must read zero.
        i_MEM_control = 3'b110; i_zero = 1'b1; i_result = 32'h100;
        i_branch_pc = 32'h1234; i_WB_control = 2'b11; i_write_reg = 5'd7;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_stall",  32'(o_stall),      32'h0);
        chk("rst_req",    32'(o_dmem_req),   32'h0);
        chk("rst_pc_src", 32'(o_pc_src),     32'h0);
        chk("rst_bpc",    o_branch_pc,       32'h0);
        chk("rst_wb",     32'(o_WB_control), 32'h0);
        chk("rst_rd",     o_read_data,       32'h0);
        chk("rst_err",    32'(o_dmem_err),   32'h0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_MEM_control = '0; i_zero = 1'b0;
        mon_en = 1'b1;

        // Directed cases.
        run_instr(3'b010, 2'b11, 32'h100, 32'h0,    32'h0,  1'b0, 5'd3, 2, 32'hDEADBEEF);
        run_instr(3'b001, 2'b00, 32'h20,  32'h55AA, 32'h0,  1'b0, 5'd0, 1, 32'h0);
        run_instr(3'b010, 2'b11, 32'h200, 32'h0,    32'h0,  1'b0, 5'd4, 0, 32'h0);
        run_instr(3'b100, 2'b00, 32'h8,   32'h0,    32'h40, 1'b1, 5'd0, 1, 32'h0);
        run_instr(3'b100, 2'b00, 32'h8,   32'h0,    32'h40, 1'b0, 5'd0, 1, 32'h0);
        run_instr(3'b011, 2'b11, 32'h30,  32'h9,    32'h0,  1'b0, 5'd5, 1, 32'h0);
        run_instr(3'b010, 2'b11, 32'h102, 32'h0,    32'h0,  1'b0, 5'd6, 1, 32'h12345678);
        run_instr(3'b000, 2'b10, 32'hABC, 32'h0,    32'h0,  1'b0, 5'd9, 1, 32'h0);
        run_instr(3'b010, 2'b01, 32'h44,  32'h0,    32'h0,  1'b0, 5'd1, TO, 32'hCAFEF00D);

        // Randomized mix.
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 9);
            lat = $urandom_range(1, 4);
            if (sel <= 2)      mc = {1'($urandom_range(0, 1)), 2'b00};
            else if (sel <= 5) mc = {1'b0, 2'b10};
            else if (sel <= 7) mc = {1'b0, 2'b01};
            else if (sel == 8) mc = {1'($urandom_range(0, 1)), 2'b11};
            else begin
                mc  = {1'b0, 1'($urandom_range(0, 1)), 1'b0};
                mc[0] = ~mc[1];
                lat = 0;
            end
            res = $urandom;
            if ($urandom_range(0, 3) != 0) res[1:0] = 2'b00;
            run_instr(mc, 2'($urandom_range(0, 3)), res, $urandom, $urandom,
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), lat, $urandom);
        end

        @(posedge i_clk);
        #1;
        i_MEM_control = '0; i_dmem_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        #3;
        mon_en = 1'b0;
        chk("queue_drained", 32'(q.size()), 32'h0);

        // Reset in the middle of an access, then an illegal control word.
        @(posedge i_clk);
        #1;
        i_MEM_control = 3'b010; i_result = 32'h200; i_WB_control = 2'b11; i_dmem_ready = 1'b0;
        @(negedge i_clk);
        #1;
        chk("mid_idle_stall", 32'(o_stall), 32'h1);
        @(negedge i_clk);
        #1;
        chk("mid_access_req", 32'(o_dmem_req), 32'h1);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_req_comb",   32'(o_dmem_req), 32'h0);
        chk("mid_rst_stall_comb", 32'(o_stall),    32'h0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_MEM_control = 3'b011;
        #1;
        chk("post_rst_req",   32'(o_dmem_req),   32'h0);
        chk("post_rst_stall", 32'(o_stall),      32'h0);
        chk("post_rst_wb",    32'(o_WB_control), 32'h0);
        chk("post_rst_err",   32'(o_dmem_err),   32'h0);
        @(posedge i_clk);
        #1;
        chk("illegal_err",   32'(o_dmem_err),   32'h1);
        chk("illegal_req",   32'(o_dmem_req),   32'h0);
        chk("illegal_wb",    32'(o_WB_control), 32'h0);
        i_MEM_control = 3'b000;
        @(posedge i_clk);
        #1;
        chk("illegal_err_pulse", 32'(o_dmem_err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
